// File: rtl/cobra_run_ctrl.sv
// rtl/cobra_run_ctrl.sv - run/step/stop sequencer driving the Cobra core clock-enable and reset
module cobra_run_ctrl #(
  parameter int PC_W       = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CMD_VALID,
  output logic            CMD_READY,
  input  logic [2:0]      CMD,
  input  logic [PC_W-1:0] CMD_ARG,
  input  logic [PC_W-1:0] PC,
  input  logic [31:0]     INSTR,
  output logic            CORE_EN,
  output logic            CORE_RST,
  output logic [2:0]      STATE,
  output logic            BP_HIT,
  output logic            SELF_LOOP,
  output logic [31:0]     INSTR_CNT
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  localparam logic [2:0] C_RUN        = 3'd1;
  localparam logic [2:0] C_STOP       = 3'd2;
  localparam logic [2:0] C_STEP       = 3'd3;
  localparam logic [2:0] C_SET_BP     = 3'd4;
  localparam logic [2:0] C_CLR_BP     = 3'd5;
  localparam logic [2:0] C_CORE_RESET = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTC = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   rst_cnt;
  logic            bp_valid;
  logic [PC_W-1:0] bp_addr;
  logic            skip;
  logic            accept;
  logic            bp_match;
  logic            loop;
  logic            unused_instr;

  assign unused_instr = ^{INSTR[30:13], INSTR[4:0]};

  assign CMD_READY = (state != S_RSTC) && (state != S_STEP);
  assign accept    = CMD_VALID && CMD_READY;
  assign bp_match  = bp_valid && (PC == bp_addr) && !skip;
  // Branch-to-self: branch opcode bit with a zero displacement field.
  assign loop      = INSTR[31] && (INSTR[12:5] == 8'd0);
  assign CORE_EN   = ((state == S_RUN) && !bp_match && !loop) || (state == S_STEP);
  assign CORE_RST  = (state == S_RSTC);
  assign STATE     = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_RSTC;
      rst_cnt   <= CW'(RST_CYCLES);
      bp_valid  <= 1'b0;
      bp_addr   <= '0;
      skip      <= 1'b0;
      BP_HIT    <= 1'b0;
      SELF_LOOP <= 1'b0;
      INSTR_CNT <= '0;
    end else begin
      if (CORE_EN && (INSTR_CNT != 32'hFFFF_FFFF)) INSTR_CNT <= INSTR_CNT + 32'd1;
      if (accept && (CMD == C_SET_BP)) begin
        bp_addr  <= CMD_ARG;
        bp_valid <= 1'b1;
      end
      if (accept && (CMD == C_CLR_BP)) bp_valid <= 1'b0;

      // Core reset overrides every stop condition and count update.
      if (accept && (CMD == C_CORE_RESET)) begin
        state     <= S_RSTC;
        rst_cnt   <= CW'(RST_CYCLES);
        INSTR_CNT <= '0;
        BP_HIT    <= 1'b0;
        SELF_LOOP <= 1'b0;
        skip      <= 1'b0;
      end else begin
        case (state)
          S_RSTC: begin
            if (rst_cnt == CW'(1)) state <= S_IDLE;
            else rst_cnt <= rst_cnt - CW'(1);
          end
          S_IDLE: begin
            if (accept && (CMD == C_RUN)) begin
              state     <= S_RUN;
              skip      <= 1'b1;
              BP_HIT    <= 1'b0;
              SELF_LOOP <= 1'b0;
            end else if (accept && (CMD == C_STEP)) begin
              state     <= S_STEP;
              BP_HIT    <= 1'b0;
              SELF_LOOP <= 1'b0;
            end
          end
          S_RUN: begin
            skip <= 1'b0;
            if (bp_match) begin
              state  <= S_IDLE;
              BP_HIT <= 1'b1;
            end else if (loop) begin
              state     <= S_DONE;
              SELF_LOOP <= 1'b1;
            end else if (accept && (CMD == C_STOP)) begin
              state <= S_IDLE;
            end
          end
          S_STEP:  state <= S_IDLE;
          S_DONE:  state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// tb/tb_cobra_run_ctrl.sv - directed self-checking bench for cobra_run_ctrl
module tb_cobra_run_ctrl;

  localparam logic [2:0] C_RUN        = 3'd1;
  localparam logic [2:0] C_STOP       = 3'd2;
  localparam logic [2:0] C_STEP       = 3'd3;
  localparam logic [2:0] C_SET_BP     = 3'd4;
  localparam logic [2:0] C_CLR_BP     = 3'd5;
  localparam logic [2:0] C_CORE_RESET = 3'd6;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [2:0]  CMD = 3'd0;
  logic [7:0]  CMD_ARG = 8'd0;
  logic [7:0]  PC;
  logic [31:0] INSTR;
  logic        CORE_EN;
  logic        CORE_RST;
  logic [2:0]  STATE;
  logic        BP_HIT;
  logic        SELF_LOOP;
  logic [31:0] INSTR_CNT;

  logic [7:0]  pc = 8'd0;
  logic        loop_on = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 CLK = ~CLK;

  // Minimal core: linear program, optional branch-to-self at address 3.
  always @(posedge CLK) begin
    if (CORE_RST) pc <= 8'd0;
    else if (CORE_EN) pc <= pc + 8'd1;
  end
  assign PC    = pc;
  assign INSTR = (loop_on && pc == 8'd3) ? 32'h8000_0000 : 32'h0000_0013;

  cobra_run_ctrl #(.PC_W(8), .RST_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD(CMD), .CMD_ARG(CMD_ARG), .PC(PC), .INSTR(INSTR),
    .CORE_EN(CORE_EN), .CORE_RST(CORE_RST), .STATE(STATE),
    .BP_HIT(BP_HIT), .SELF_LOOP(SELF_LOOP), .INSTR_CNT(INSTR_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] a);
    CMD = c;
    CMD_ARG = a;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    CMD = 3'd0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (STATE !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {29'd0, STATE}, {29'd0, s});
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_state", {29'd0, STATE}, 32'd1);
    chk("rst_core_rst", {31'd0, CORE_RST}, 32'd1);
    chk("rst_core_en", {31'd0, CORE_EN}, 32'd0);
    chk("rst_ready", {31'd0, CMD_READY}, 32'd0);
    chk("rst_cnt", INSTR_CNT, 32'd0);
    chk("rst_flags", {30'd0, BP_HIT, SELF_LOOP}, 32'd0);
    RST = 1'b1;
    tick();
    chk("rel1_state", {29'd0, STATE}, 32'd1);
    chk("rel1_core_rst", {31'd0, CORE_RST}, 32'd1);
    tick();
    chk("rel2_state", {29'd0, STATE}, 32'd0);
    chk("rel2_core_rst", {31'd0, CORE_RST}, 32'd0);
    chk("rel2_ready", {31'd0, CMD_READY}, 32'd1);
    chk("rel2_cnt", INSTR_CNT, 32'd0);

    for (int i = 0; i < 3; i++) begin
      chk("step_ready_before", {31'd0, CMD_READY}, 32'd1);
      send(C_STEP, 8'd0);
      chk("step_en", {31'd0, CORE_EN}, 32'd1);
      chk("step_ready_busy", {31'd0, CMD_READY}, 32'd0);
      tick();
      chk("step_en_after", {31'd0, CORE_EN}, 32'd0);
      chk("step_idle", {29'd0, STATE}, 32'd0);
    end
    chk("step_cnt", INSTR_CNT, 32'd3);

    send(C_CORE_RESET, 8'd0);
    chk("creset_state", {29'd0, STATE}, 32'd1);
    chk("creset_cnt", INSTR_CNT, 32'd0);
    wait_state(3'd0, 10, "creset_idle");

    send(C_SET_BP, 8'h02);
    send(C_RUN, 8'd0);
    wait_state(3'd0, 20, "bp_idle");
    chk("bp_pc", {24'd0, PC}, 32'h02);
    chk("bp_core_en", {31'd0, CORE_EN}, 32'd0);
    chk("bp_hit", {31'd0, BP_HIT}, 32'd1);
    chk("bp_cnt", INSTR_CNT, 32'd2);
    send(C_RUN, 8'd0);
    chk("bp_resume_clr", {31'd0, BP_HIT}, 32'd0);
    chk("bp_resume_en", {31'd0, CORE_EN}, 32'd1);
    tick();
    chk("bp_resume_pc", {24'd0, PC}, 32'h03);
    send(C_STOP, 8'd0);
    chk("stop_idle", {29'd0, STATE}, 32'd0);
    chk("stop_cnt", INSTR_CNT, 32'd4);
    tick();
    chk("stop_frozen", INSTR_CNT, 32'd4);
    chk("stop_en", {31'd0, CORE_EN}, 32'd0);

    send(C_CLR_BP, 8'd0);
    send(C_CORE_RESET, 8'd0);
    wait_state(3'd0, 10, "loop_pre_idle");
    loop_on = 1'b1;
    send(C_RUN, 8'd0);
    wait_state(3'd4, 20, "loop_done");
    chk("loop_flag", {31'd0, SELF_LOOP}, 32'd1);
    chk("loop_cnt", INSTR_CNT, 32'd3);
    chk("loop_en", {31'd0, CORE_EN}, 32'd0);
    send(C_RUN, 8'd0);
    chk("loop_run_ignored", {29'd0, STATE}, 32'd4);
    chk("loop_run_cnt", INSTR_CNT, 32'd3);
    send(C_CORE_RESET, 8'd0);
    chk("loop_rstc", {29'd0, STATE}, 32'd1);
    wait_state(3'd0, 10, "loop_reset_idle");
    chk("loop_reset_cnt", INSTR_CNT, 32'd0);
    chk("loop_reset_flag", {31'd0, SELF_LOOP}, 32'd0);

    send(C_SET_BP, 8'h03);
    send(C_RUN, 8'd0);
    wait_state(3'd0, 20, "bploop_idle");
    chk("bploop_hit", {31'd0, BP_HIT}, 32'd1);
    chk("bploop_self", {31'd0, SELF_LOOP}, 32'd0);
    chk("bploop_cnt", INSTR_CNT, 32'd3);

    send(C_CLR_BP, 8'd0);
    send(C_CORE_RESET, 8'd0);
    wait_state(3'd0, 10, "arst_pre_idle");
    loop_on = 1'b0;
    send(C_RUN, 8'd0);
    tick();
    chk("arst_running", {31'd0, CORE_EN}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_en", {31'd0, CORE_EN}, 32'd0);
    chk("arst_state", {29'd0, STATE}, 32'd1);
    chk("arst_core_rst", {31'd0, CORE_RST}, 32'd1);
    chk("arst_ready", {31'd0, CMD_READY}, 32'd0);
    chk("arst_cnt", INSTR_CNT, 32'd0);
    chk("arst_flags", {30'd0, BP_HIT, SELF_LOOP}, 32'd0);
    tick();
    RST = 1'b1;
    wait_state(3'd0, 10, "arst_recover");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cobra_run_ctrl.md
# cobra_run_ctrl

Run/debug controller for the Cobra single-cycle core. It sequences the core through reset, free-run, single-step and stop by driving the core's clock-enable and synchronous reset. It stops the core on a PC breakpoint or on an unconditional branch-to-self, which is the program-end idiom. It sits between a host command port and the core's `CLK` gating / `RST` input, and observes the core's `PC` and `INSTR` buses.

## Interface
- `PC_W`, 8: width of core PC and breakpoint address.
- `RST_CYCLES`, 2: core reset hold length in cycles, ≥1.

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-low reset of this block.
- `CMD_VALID`  in  1  host command valid.
- `CMD_READY`  out  1  block can accept a command.
- `CMD`  in  3  0 NOP, 1 RUN, 2 STOP, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CORE_RESET, 7 reserved (treated as NOP).
- `CMD_ARG`  in  PC_W  breakpoint address for SET_BP.
- `PC`  in  PC_W  core PC, which is the address of the instruction currently presented.
- `INSTR`  in  32  core instruction word at `PC`.
- `CORE_EN`  out  1  core PC/register-file update enable for this cycle.
- `CORE_RST`  out  1  active-high synchronous reset to the core.
- `STATE`  out  3  encodings: IDLE=0, RSTC=1, RUN=2, STEP=3, DONE=4.
- `BP_HIT`  out  1  sticky: stopped on breakpoint.
- `SELF_LOOP`  out  1  sticky: stopped on branch-to-self.
- `INSTR_CNT`  out  32  count of cycles with `CORE_EN`=1 since the last core reset; saturating.

## Operation
- A command is accepted on a rising edge with `CMD_VALID & CMD_READY`. Its effect is visible from the next cycle.
- `CMD_READY` = 0 in RSTC and STEP, and 1 otherwise.
- Stop conditions (combinational on `PC`/`INSTR`):
  - `bp_match` = `bp_valid & (PC == bp_addr) & ~skip`.
  - `loop` = `INSTR[31] & (INSTR[12:5] == 0)`.
- `CORE_EN` (combinational):
  - In RUN: 1 when neither `bp_match` nor `loop` holds.
  - In STEP: 1.
  - Otherwise: 0.
- `CORE_RST` = 1 only in RSTC.
- States:
  - RSTC: a down-counter is loaded with `RST_CYCLES`; the block moves to IDLE when the counter reaches 1. `INSTR_CNT` is held at 0.
  - IDLE:
    - RUN goes to RUN and sets `skip`.
    - STEP goes to STEP.
    - CORE_RESET goes to RSTC.
    - STOP is a no-op.
  - RUN:
    - If `loop` holds and `bp_match` does not, go to DONE and set `SELF_LOOP`.
    - If `bp_match` holds, go to IDLE and set `BP_HIT`. A breakpoint wins over a self-loop when both hold in the same cycle.
    - An accepted STOP goes to IDLE. If STOP coincides with a stop condition, the state goes to IDLE or DONE as the stop condition dictates, and the sticky flag is still set.
    - An accepted CORE_RESET goes to RSTC and overrides everything else.
  - STEP: exactly one cycle with `CORE_EN`=1, ignoring breakpoint and self-loop, then IDLE.
  - DONE:
    - RUN and STEP are ignored.
    - CORE_RESET goes to RSTC.
    - SET_BP and CLR_BP are accepted.
- `skip`:
  - Set on RUN acceptance.
  - Cleared after the first cycle in RUN, whether or not `CORE_EN` was 1 in that cycle.
  - This lets RUN resume from a breakpoint address.
- SET_BP loads `bp_addr` from `CMD_ARG` and sets `bp_valid`. CLR_BP clears `bp_valid`. Both are legal in any state where ready is high and do not change state.
- `BP_HIT` and `SELF_LOOP` are cleared on acceptance of RUN, STEP or CORE_RESET.
- `INSTR_CNT`:
  - Increments on each edge with `CORE_EN`=1.
  - Saturates at 0xFFFFFFFF.
  - Zeroed on entry to RSTC.

## Timing
- Reset values while `RST`=0:
  - `STATE`=RSTC, `CORE_RST`=1, `CORE_EN`=0, `CMD_READY`=0.
  - `BP_HIT`=0, `SELF_LOOP`=0, `INSTR_CNT`=0.
  - `bp_valid`=0, `bp_addr`=0, `skip`=0, counter=`RST_CYCLES`.
- After `RST` rises, `CORE_RST` stays high for `RST_CYCLES` edges. IDLE follows.
- An asynchronous `RST` assertion mid-RUN drops `CORE_EN` immediately, with no edge required.
- `CORE_EN`/stop decisions have zero latency. The core never executes the instruction at the breakpoint or the self-loop in RUN.
- One STEP command produces one `CORE_EN` cycle. A back-to-back STEP is accepted at the earliest two edges after the previous one.

## Test plan
- Reset release with `RST_CYCLES`=2:
  - `STATE` reads 1, 1, then 0.
  - `CORE_RST` is high for exactly 2 edges, then `CMD_READY`=1.
  - `INSTR_CNT`=0.
- Three STEP commands, each issued as soon as ready:
  - `CORE_EN` shows three isolated one-cycle pulses.
  - `CMD_READY`=0 during each STEP.
  - `INSTR_CNT`=3 and `STATE`=IDLE.
- SET_BP 0x02, then RUN from PC 0, using a linear program:
  - Stops with PC=0x02, `CORE_EN`=0, `BP_HIT`=1, `INSTR_CNT`=2, `STATE`=IDLE.
  - A second RUN executes PC 0x02 and clears `BP_HIT`.
- Program with `INSTR`=0x80000000 at PC 0x03, run from 0:
  - `STATE`=DONE, `SELF_LOOP`=1, `INSTR_CNT`=3.
  - RUN is ignored.
  - CORE_RESET leads to RSTC, then IDLE with `INSTR_CNT`=0 and `SELF_LOOP`=0.
- Breakpoint at 0x03 on the self-loop address: stops in IDLE with `BP_HIT`=1 and `SELF_LOOP`=0.
- During RUN:
  - STOP gives IDLE on the next cycle, with `INSTR_CNT` frozen.
  - Asserting `RST` low mid-RUN gives `CORE_EN`=0 without a clock edge, and all outputs at reset values.
